gcd_stein_engine: RTL

Parametrised, handshaked GCD engine: the successor to the fixed 16-bit subtract-and-compare GCD datapath/controller pair. It computes gcd(A, B) with the binary (Stein) algorithm, doing one shift or subtract-shift step per clock, for any operand width. Operand intake uses a valid/ready handshake, result delivery uses a valid/ready handshake, and a user tag passes through. It sits between a request source and a result consumer in the arithmetic-block set.

---
 rtl/gcd_pkg.sv | 20 ++
 rtl/gcd_step.sv | 36 +++
 rtl/gcd_stein_engine.sv | 127 ++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types and sizing helpers for the binary-GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STRIP = 2'd1,
    ST_CORE  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Worst-case acceptance-to-result cycles is LAT_MUL*WIDTH + LAT_ADD.
  localparam int LAT_MUL = 3;
  localparam int LAT_ADD = 2;

  // Width of the common-factor-of-two counter; must be able to hold WIDTH.
  function automatic int shift_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/gcd_step.sv
// One Stein CORE step: strip a factor of two from a or b, else subtract-and-halve.
module gcd_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_nxt_o,
  output logic [WIDTH-1:0] b_nxt_o,
  output logic             a_even_o,
  output logic             b_even_o,
  output logic             eq_o,
  output logic             a_gt_b_o
);

  always_comb begin
    a_even_o = ~a_i[0];
    b_even_o = ~b_i[0];
    eq_o     = (a_i == b_i);
    a_gt_b_o = (a_i > b_i);
    a_nxt_o  = a_i;
    b_nxt_o  = b_i;
    // Both odd by the time we subtract, so the difference is even and halving is exact.
    if (a_even_o) begin
      a_nxt_o = a_i >> 1;
    end else if (b_even_o) begin
      b_nxt_o = b_i >> 1;
    end else if (eq_o) begin
      a_nxt_o = a_i;
    end else if (a_gt_b_o) begin
      a_nxt_o = (a_i - b_i) >> 1;
    end else begin
      b_nxt_o = (b_i - a_i) >> 1;
    end
  end

endmodule

// File: rtl/gcd_stein_engine.sv
// Handshaked binary-GCD engine: one shift or subtract-shift per cycle, tag passes through.
// Result is held in DONE until out_valid && out_ready; no request is accepted outside IDLE.
module gcd_stein_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int KW = shift_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
  logic [KW-1:0]    k_q, k_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] step_a, step_b;
  logic             step_a_even, step_b_even, step_eq, step_a_gt_b;
  logic             core_done;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a_i      (a_q),
    .b_i      (b_q),
    .a_nxt_o  (step_a),
    .b_nxt_o  (step_b),
    .a_even_o (step_a_even),
    .b_even_o (step_b_even),
    .eq_o     (step_eq),
    .a_gt_b_o (step_a_gt_b)
  );

  assign core_done = step_eq & ~(step_a_even | step_b_even | step_a_gt_b);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    tag_d   = tag_q;
    gcd_d   = gcd_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d   = in_a;
          b_d   = in_b;
          tag_d = in_tag;
          k_d   = '0;
          if ((in_a == '0) || (in_b == '0)) begin
            gcd_d   = in_a | in_b;
            zero_d  = (in_a == '0) && (in_b == '0);
            state_d = ST_DONE;
          end else begin
            zero_d  = 1'b0;
            state_d = ST_STRIP;
          end
        end
      end
      ST_STRIP: begin
        if (!a_q[0] && !b_q[0]) begin
          a_d = a_q >> 1;
          b_d = b_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = ST_CORE;
        end
      end
      ST_CORE: begin
        // k never exceeds the stripped bits, so the shift cannot overflow WIDTH.
        if (core_done) begin
          gcd_d   = a_q << k_q;
          state_d = ST_DONE;
        end else begin
          a_d = step_a;
          b_d = step_b;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      tag_q   <= '0;
      gcd_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      tag_q   <= tag_d;
      gcd_q   <= gcd_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_gcd   = gcd_q;
  assign out_zero  = zero_q;
  assign out_tag   = tag_q;

endmodule
